// File: rtl/ascon_output_serializer.sv
// Buffers the cipher blocks and the authentication tag of one ascon message
// and streams them out MSB-first as a valid/ready byte stream, one byte per cycle.
module ascon_output_serializer #(
   parameter int NB_BLOCKS = 24
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic [63:0]  cipher_i,
   input  logic         cipher_valid_i,
   input  logic [127:0] tag_i,
   input  logic         end_tag_i,
   output logic [7:0]   byte_o,
   output logic         byte_valid_o,
   input  logic         byte_ready_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         overflow_o,
   output logic [4:0]   block_count_o
);

   localparam logic [4:0] NB_MAX = 5'(NB_BLOCKS);

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      SEND_CIPHER,
      SEND_TAG,
      DONE
   } state_t;

   state_t       state;
   state_t       state_nxt;

   logic [63:0]  buffer [NB_BLOCKS];
   logic [127:0] tag_q;
   logic [4:0]   block_count;
   logic [4:0]   blk_idx;
   logic [3:0]   byte_sel;
   logic         cv_q;
   logic         overflow;

   logic         capture;
   logic         arm;
   logic         restart;
   logic         store;
   logic         drop;
   logic         tag_hit;
   logic         take;
   logic         cipher_last;
   logic [63:0]  cur_block;

   // NOTE: every signal driven here gets a default first, so no path can leave
   // a value unassigned and infer a latch.
   always_comb begin
      capture     = 1'b0;
      arm         = 1'b0;
      restart     = 1'b0;
      store       = 1'b0;
      drop        = 1'b0;
      tag_hit     = 1'b0;
      take        = 1'b0;
      cipher_last = 1'b0;

      capture = cipher_valid_i & ~cv_q;
      arm     = start_i && (state == IDLE || state == DONE);
      restart = start_i && (state == COLLECT);

      // A restart in COLLECT takes priority over any capture or tag that cycle.
      if (state == COLLECT && !start_i) begin
         store   = capture && (block_count < NB_MAX);
         drop    = capture && (block_count >= NB_MAX);
         tag_hit = end_tag_i;
      end

      take        = byte_valid_o && byte_ready_i;
      cipher_last = (blk_idx == 5'(block_count - 5'd1)) && (byte_sel[2:0] == 3'd7);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start_i) state_nxt = COLLECT;
         end
         COLLECT: begin
            // A block stored in the tag cycle counts towards the cipher phase.
            if (tag_hit) begin
               if (store || block_count != 5'd0) state_nxt = SEND_CIPHER;
               else                              state_nxt = SEND_TAG;
            end
         end
         SEND_CIPHER: begin
            if (take && cipher_last) state_nxt = SEND_TAG;
         end
         SEND_TAG: begin
            if (take && byte_sel == 4'd15) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         cv_q        <= 1'b0;
         block_count <= '0;
         overflow    <= 1'b0;
         blk_idx     <= '0;
         byte_sel    <= '0;
         tag_q       <= '0;
      end else begin
         cv_q <= cipher_valid_i;
         if (arm || restart) begin
            block_count <= '0;
            overflow    <= 1'b0;
            blk_idx     <= '0;
            byte_sel    <= '0;
         end else begin
            if (store)   block_count <= block_count + 5'd1;
            if (drop)    overflow    <= 1'b1;
            if (tag_hit) tag_q       <= tag_i;
            if (take) begin
               if (state == SEND_CIPHER) begin
                  if (byte_sel[2:0] == 3'd7) begin
                     byte_sel <= '0;
                     blk_idx  <= cipher_last ? 5'd0 : blk_idx + 5'd1;
                  end else begin
                     byte_sel <= byte_sel + 4'd1;
                  end
               end else begin
                  // Wraps back to 0 after the 16th tag byte.
                  byte_sel <= byte_sel + 4'd1;
               end
            end
         end
      end
   end

   // NOTE: the block buffer is deliberately left out of reset; it is always
   // written before it is read, and a resettable memory cannot map to RAM.
   always_ff @(posedge clock_i) begin
      if (store) buffer[block_count] <= cipher_i;
   end

   always_comb begin
      cur_block = buffer[blk_idx];
      byte_o    = 8'h00;
      case (state)
         SEND_CIPHER: byte_o = cur_block[{~byte_sel[2:0], 3'b000} +: 8];
         SEND_TAG:    byte_o = tag_q[{~byte_sel, 3'b000} +: 8];
         default:     byte_o = 8'h00;
      endcase
   end

   assign byte_valid_o  = (state == SEND_CIPHER) || (state == SEND_TAG);
   assign busy_o        = (state == COLLECT) || byte_valid_o;
   assign done_o        = (state == DONE);
   assign overflow_o    = overflow;
   assign block_count_o = block_count;

endmodule
